// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares the single-port character RAM between display refresh and a host
//   writer/reader. Once per 16-clock character slot (h_pixel == 12) one RAM
//   cycle is taken to prefetch the next cell's character code. That code is
//   presented on glyph for the whole following slot. Every other cycle
//   belongs to the host, through a valid/ready handshake with a fixed
//   two-cycle read latency.
//
// Ports
//   clk, reset_low              pixel clock, asynchronous active-low reset
//   h_block, h_pixel,
//   v_block, v_pixel            raster position from the vga timing generator
//   host_valid / host_ready     request handshake (ready never looks at valid)
//   host_write, host_addr,
//   host_wdata                  request payload (1 = write, 0 = read)
//   host_rvalid, host_rdata     one-cycle read-data pulse
//   ram_addr, ram_we,
//   ram_wdata                   combinational RAM command for this cycle
//   ram_rdata                   synchronous RAM data, one cycle after address
//   glyph                       registered character code for the current cell
module vram_arbiter #(
    parameter int          COLUMNS        = 50,
    parameter int          ROWS           = 20,
    parameter int          CELL_HEIGHT    = 24,
    parameter int          H_TOTAL_BLOCKS = 66,
    parameter int          ADDR_WIDTH     = 11,
    parameter logic [7:0]  BLANK          = 8'h20
) (
    input  logic                  clk,
    input  logic                  reset_low,
    input  logic [6:0]            h_block,
    input  logic [3:0]            h_pixel,
    input  logic [4:0]            v_block,
    input  logic [4:0]            v_pixel,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic                  host_write,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [7:0]            host_wdata,
    output logic                  host_rvalid,
    output logic [7:0]            host_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata,
    output logic [7:0]            glyph
);

    // Owner of ram_rdata in the cycle after the command.
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_DISPLAY,
        TAG_HOST_RAM,
        TAG_HOST_OOR
    } tag_e;

    tag_e                  tag_q, tag_d;
    logic [7:0]            next_glyph_q;
    logic [7:0]            glyph_q;
    logic                  rvalid_q;
    logic [7:0]            rdata_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [7:0]            ram_wdata_q;

    logic                  last_block;
    logic [7:0]            tgt_col;
    logic [5:0]            tgt_row;
    logic                  tgt_valid;
    logic                  fetch;
    logic [ADDR_WIDTH-1:0] disp_addr;
    logic                  host_acc;
    logic                  host_in_range;

    // Prefetch target: the cell after the current one; the last block of a
    // line wraps to column 0, advancing the row only on the last scanline of
    // the text row.
    always_comb begin
        last_block = (h_block == 7'(H_TOTAL_BLOCKS - 1));
        tgt_col    = last_block ? 8'd0 : ({1'b0, h_block} + 8'd1);
        tgt_row    = (last_block && (v_pixel == 5'(CELL_HEIGHT - 1)))
                     ? ({1'b0, v_block} + 6'd1) : {1'b0, v_block};
        tgt_valid  = (tgt_col < 8'(COLUMNS)) && (tgt_row < 6'(ROWS));
        fetch      = (h_pixel == 4'd12) && tgt_valid;
        // Only valid targets are ever used, and those fit ADDR_WIDTH exactly.
        disp_addr  = ADDR_WIDTH'(tgt_row) * ADDR_WIDTH'(COLUMNS)
                     + ADDR_WIDTH'(tgt_col);
    end

    // Arbitration: the display fetch always wins; ready is a pure function
    // of raster position.
    always_comb begin
        host_ready    = !fetch;
        host_acc      = host_valid && !fetch;
        // Compare one bit wider so ROWS*COLUMNS == 2^ADDR_WIDTH is handled.
        host_in_range = ({1'b0, host_addr} < (ADDR_WIDTH + 1)'(ROWS * COLUMNS));
    end

    // RAM command; with no request the address/data simply hold.
    always_comb begin
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wdata_q;
        ram_we    = 1'b0;
        tag_d     = TAG_NONE;
        if (fetch) begin
            ram_addr = disp_addr;
            tag_d    = TAG_DISPLAY;
        end else if (host_acc) begin
            if (host_write) begin
                ram_addr  = host_addr;
                ram_wdata = host_wdata;
                ram_we    = host_in_range;
            end else if (host_in_range) begin
                ram_addr = host_addr;
                tag_d    = TAG_HOST_RAM;
            end else begin
                tag_d    = TAG_HOST_OOR;
            end
        end
    end

    always_ff @(posedge clk) begin
        ram_addr_q  <= ram_addr;
        ram_wdata_q <= ram_wdata;
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            tag_q        <= TAG_NONE;
            next_glyph_q <= BLANK;
            glyph_q      <= BLANK;
            rvalid_q     <= 1'b0;
            rdata_q      <= 8'h00;
        end else begin
            tag_q    <= tag_d;
            rvalid_q <= (tag_q == TAG_HOST_RAM) || (tag_q == TAG_HOST_OOR);
            if (tag_q == TAG_HOST_RAM) begin
                rdata_q <= ram_rdata;
            end else if (tag_q == TAG_HOST_OOR) begin
                rdata_q <= BLANK;
            end
            // A fetch at h_pixel 12 returns data at 13; if no fetch happened
            // the slot's next glyph is blank.
            if (tag_q == TAG_DISPLAY) begin
                next_glyph_q <= ram_rdata;
            end else if (h_pixel == 4'd13) begin
                next_glyph_q <= BLANK;
            end
            if (h_pixel == 4'd15) begin
                glyph_q <= next_glyph_q;
            end
        end
    end

    assign host_rvalid = rvalid_q;
    assign host_rdata  = rdata_q;
    assign glyph       = glyph_q;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_low;
    logic [6:0]  h_block;
    logic [3:0]  h_pixel;
    logic [4:0]  v_block;
    logic [4:0]  v_pixel;
    logic        host_valid;
    logic        host_ready;
    logic        host_write;
    logic [10:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_rvalid;
    logic [7:0]  host_rdata;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  glyph;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] mem [0:2047];

    vram_arbiter dut (
        .clk(clk), .reset_low(reset_low),
        .h_block(h_block), .h_pixel(h_pixel), .v_block(v_block), .v_pixel(v_pixel),
        .host_valid(host_valid), .host_ready(host_ready), .host_write(host_write),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .glyph(glyph)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port character RAM.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read-data monitor: pops the scoreboard whenever the DUT pulses rvalid,
    // and flags any expectation whose cycle has passed unseen.
    always @(negedge clk) begin
        if (host_rvalid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rvalid: got rvalid=1 data=%0h, expected none (cycle %0d)",
                         host_rdata, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rvalid_cycle", cyc, e.cyc);
                chk("rdata", {24'd0, host_rdata}, {24'd0, e.data});
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_rvalid: got rvalid=0, expected pulse data=%0h (cycle %0d)",
                     e.data, cyc);
        end
    end

    task automatic set_pos(input int vb, input int vp, input int hb, input int hp);
        v_block = 5'(vb); v_pixel = 5'(vp); h_block = 7'(hb); h_pixel = 4'(hp);
    endtask

    task automatic adv();
        if (h_pixel == 4'd15) begin
            h_pixel = 4'd0;
            if (h_block == 7'd65) begin
                h_block = 7'd0;
                if (v_pixel == 5'd23) begin
                    v_pixel = 5'd0;
                    v_block = v_block + 5'd1;
                end else begin
                    v_pixel = v_pixel + 5'd1;
                end
            end else begin
                h_block = h_block + 7'd1;
            end
        end else begin
            h_pixel = h_pixel + 4'd1;
        end
    endtask

    task automatic host_req(input logic wr, input int addr, input logic [7:0] data);
        host_valid = 1'b1; host_write = wr; host_addr = 11'(addr); host_wdata = data;
    endtask

    task automatic host_idle();
        host_valid = 1'b0; host_write = 1'b0;
    endtask

    // Issue a read in the current cycle and record its expected pulse.
    task automatic host_read(input int addr, input logic [7:0] exp_data);
        exp_t e;
        host_req(1'b0, addr, 8'h00);
        e.cyc  = cyc + 2;
        e.data = exp_data;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        reset_low = 1'b0;
        host_idle();
        host_addr = 11'd0; host_wdata = 8'h00;
        set_pos(0, 0, 60, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_glyph", {24'd0, glyph}, 32'h20);
        chk("reset_rdata", {24'd0, host_rdata}, 32'h0);
        chk("reset_rvalid", {31'd0, host_rvalid}, 32'h0);
        chk("reset_ready", {31'd0, host_ready}, 32'h1);
        @(negedge clk);
        reset_low = 1'b1;

        // Host writes: 0x41 -> 51, 0x42 -> 52.
        @(negedge clk);
        set_pos(0, 0, 60, 0);
        host_req(1'b1, 51, 8'h41);
        #1;
        chk("wr_ready", {31'd0, host_ready}, 32'h1);
        chk("wr_we", {31'd0, ram_we}, 32'h1);
        chk("wr_addr", {21'd0, ram_addr}, 32'd51);
        chk("wr_wdata", {24'd0, ram_wdata}, 32'h41);
        @(negedge clk);
        set_pos(0, 0, 60, 1);
        host_req(1'b1, 52, 8'h42);
        @(negedge clk);
        host_idle();

        // Write then display: prefetch of cell (1,1) and its glyph.
        set_pos(1, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            #1;
            if (h_block == 7'd0 && h_pixel == 4'd12) begin
                chk("disp_addr", {21'd0, ram_addr}, 32'd51);
                chk("disp_ready", {31'd0, host_ready}, 32'h0);
                chk("disp_we", {31'd0, ram_we}, 32'h0);
            end
            if (h_block == 7'd1) chk("disp_glyph", {24'd0, glyph}, 32'h41);
            @(negedge clk);
            adv();
        end

        // Row-boundary prefetch.
        set_pos(0, 23, 65, 12);
        #1;
        chk("wrap_next_row", {21'd0, ram_addr}, 32'd50);
        chk("wrap_ready", {31'd0, host_ready}, 32'h0);
        @(negedge clk);
        set_pos(0, 5, 65, 12);
        #1;
        chk("wrap_same_row", {21'd0, ram_addr}, 32'd0);
        @(negedge clk);

        // Stall around the fetch cycle: write 0x7E to address 3.
        set_pos(0, 0, 5, 11);
        host_req(1'b1, 3, 8'h7E);
        #1;
        chk("stall_ready11", {31'd0, host_ready}, 32'h1);
        chk("stall_we11", {31'd0, ram_we}, 32'h1);
        chk("stall_addr11", {21'd0, ram_addr}, 32'd3);
        @(negedge clk);
        adv();
        #1;
        chk("stall_ready12", {31'd0, host_ready}, 32'h0);
        chk("stall_addr12", {21'd0, ram_addr}, 32'd6);
        chk("stall_we12", {31'd0, ram_we}, 32'h0);
        @(negedge clk);
        adv();
        #1;
        chk("stall_ready13", {31'd0, host_ready}, 32'h1);
        chk("stall_we13", {31'd0, ram_we}, 32'h1);
        @(negedge clk);
        host_idle();

        // Read latency and back-to-back ordering.
        set_pos(0, 0, 60, 0);
        host_read(51, 8'h41);
        #1;
        chk("rd_we", {31'd0, ram_we}, 32'h0);
        chk("rd_addr", {21'd0, ram_addr}, 32'd51);
        @(negedge clk); adv(); host_idle();
        @(negedge clk); adv(); host_read(51, 8'h41);
        @(negedge clk); adv(); host_read(52, 8'h42);
        @(negedge clk); adv(); host_read(3, 8'h7E);
        @(negedge clk); adv(); host_idle();

        // Out-of-range write and read.
        host_req(1'b1, 1000, 8'h55);
        #1;
        chk("oor_we", {31'd0, ram_we}, 32'h0);
        chk("oor_ready", {31'd0, host_ready}, 32'h1);
        @(negedge clk); adv(); host_read(1000, 8'h20);
        @(negedge clk); adv(); host_idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_reads", exp_q.size(), 32'd0);

        // Blank glyph outside the text area.
        set_pos(0, 0, 53, 0);
        for (int i = 0; i < 48; i++) begin
            #1;
            if (h_block == 7'd55 && (h_pixel == 4'd0 || h_pixel == 4'd15))
                chk("oor_glyph", {24'd0, glyph}, 32'h20);
            @(negedge clk);
            adv();
        end

        // Reset in the cycle after a read was accepted.
        set_pos(0, 0, 60, 0);
        set_pos(0, 0, 1, 15);
        @(negedge clk);
        adv();
        host_req(1'b0, 51, 8'h00);
        @(negedge clk);
        host_idle();
        reset_low = 1'b0;
        #1;
        chk("rst_glyph", {24'd0, glyph}, 32'h20);
        chk("rst_rdata", {24'd0, host_rdata}, 32'h0);
        chk("rst_rvalid", {31'd0, host_rvalid}, 32'h0);
        @(negedge clk);
        reset_low = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_rdata_after", {24'd0, host_rdata}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
